// File: rtl/pong_motion_ctrl.sv
`timescale 1ns/1ps
// Pong playfield sequencer: paddle/ball motion and the IDLE/PLAY/MISS game
// FSM, all updated once per frame on the registered frame tick.
module pong_motion_ctrl #(
    parameter int MAX_Y       = 480,
    parameter int WALL_X_R    = 35,
    parameter int BAR_X_L     = 600,
    parameter int BAR_X_R     = 603,
    parameter int BAR_H       = 72,
    parameter int BAR_V       = 4,
    parameter int BALL_SIZE   = 8,
    parameter int BALL_V      = 2,
    parameter int BALL_X0     = 580,
    parameter int BALL_Y0     = 238,
    parameter int BAR_Y0      = 204,
    parameter int MISS_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [9:0] bar_y_t,
    output logic [9:0] ball_x_l,
    output logic [9:0] ball_y_t,
    output logic       ball_visible,
    output logic       frame_tick,
    output logic       hit,
    output logic       miss
);

    localparam int CW = $clog2(MISS_FRAMES);

    localparam logic [10:0] TOP_LIM  = 11'(BALL_V);
    localparam logic [10:0] BOT_LIM  = 11'(MAX_Y - BALL_V);
    localparam logic [10:0] WALL_LIM = 11'(WALL_X_R + BALL_V);
    localparam logic [10:0] PAD_LO   = 11'(BAR_X_L - BALL_V);
    localparam logic [10:0] PAD_HI   = 11'(BAR_X_R);
    localparam logic [10:0] BAR_MAX  = 11'(MAX_Y - BAR_H);

    localparam logic [9:0] TICK_Y  = 10'(MAX_Y + 1);
    localparam logic [9:0] STEP_B  = 10'(BAR_V);
    localparam logic [9:0] STEP_V  = 10'(BALL_V);
    localparam logic [9:0] X0      = 10'(BALL_X0);
    localparam logic [9:0] Y0      = 10'(BALL_Y0);
    localparam logic [9:0] BAR0    = 10'(BAR_Y0);
    localparam logic [9:0] BAR_TOP = 10'(MAX_Y - BAR_H);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        MISS
    } state_t;

    state_t state_q, state_d;

    logic          dir_x_q, dir_x_d;
    logic          dir_y_q, dir_y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    bar_d, bx_d, by_d;
    logic          vis_d, hit_d, miss_d, tick_d;

    logic [10:0] bar_w, bx_w, by_w, ball_r, ball_b;
    logic        at_top, at_bot, at_wall, at_pad, past_bar;

    assign bar_w  = {1'b0, bar_y_t};
    assign bx_w   = {1'b0, ball_x_l};
    assign by_w   = {1'b0, ball_y_t};
    assign ball_r = bx_w + 11'(BALL_SIZE - 1);
    assign ball_b = by_w + 11'(BALL_SIZE - 1);

    assign at_top   = by_w <= TOP_LIM;
    assign at_bot   = by_w + 11'(BALL_SIZE) >= BOT_LIM;
    assign at_wall  = bx_w <= WALL_LIM;
    assign past_bar = bx_w > PAD_HI;
    // collision uses the paddle position from before this frame's move
    assign at_pad   = dir_x_q
                   && ball_r >= PAD_LO && ball_r <= PAD_HI
                   && ball_b >= bar_w
                   && by_w <= bar_w + 11'(BAR_H - 1);

    always_comb begin
        state_d = state_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        cnt_d   = cnt_q;
        bar_d   = bar_y_t;
        bx_d    = ball_x_l;
        by_d    = ball_y_t;
        vis_d   = ball_visible;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        tick_d  = (pixel_x == 10'd0) && (pixel_y == TICK_Y);

        if (frame_tick) begin
            if (btn_up && !btn_down) begin
                bar_d = (bar_w < 11'(BAR_V)) ? 10'd0 : bar_y_t - STEP_B;
            end else if (btn_down && !btn_up) begin
                bar_d = (bar_w + 11'(BAR_V) > BAR_MAX) ? BAR_TOP
                                                        : bar_y_t + STEP_B;
            end

            unique case (state_q)
                IDLE: begin
                    bx_d  = X0;
                    by_d  = Y0;
                    vis_d = 1'b1;
                    if (btn_up || btn_down) begin
                        state_d = PLAY;
                        dir_x_d = 1'b0;
                        dir_y_d = 1'b1;
                    end
                end
                PLAY: begin
                    if (at_top) begin
                        dir_y_d = 1'b1;
                    end else if (at_bot) begin
                        dir_y_d = 1'b0;
                    end
                    if (past_bar) begin
                        state_d = MISS;
                        miss_d  = 1'b1;
                        vis_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        if (at_wall) begin
                            dir_x_d = 1'b1;
                        end else if (at_pad) begin
                            dir_x_d = 1'b0;
                            hit_d   = 1'b1;
                        end
                        bx_d = dir_x_d ? ball_x_l + STEP_V : ball_x_l - STEP_V;
                        by_d = dir_y_d ? ball_y_t + STEP_V : ball_y_t - STEP_V;
                    end
                end
                MISS: begin
                    if (cnt_q == CW'(MISS_FRAMES - 1)) begin
                        state_d = IDLE;
                        bx_d    = X0;
                        by_d    = Y0;
                        vis_d   = 1'b1;
                        dir_x_d = 1'b0;
                        dir_y_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            dir_x_q      <= 1'b0;
            dir_y_q      <= 1'b1;
            cnt_q        <= '0;
            bar_y_t      <= BAR0;
            ball_x_l     <= X0;
            ball_y_t     <= Y0;
            ball_visible <= 1'b1;
            frame_tick   <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            cnt_q        <= cnt_d;
            bar_y_t      <= bar_d;
            ball_x_l     <= bx_d;
            ball_y_t     <= by_d;
            ball_visible <= vis_d;
            frame_tick   <= tick_d;
            hit          <= hit_d;
            miss         <= miss_d;
        end
    end

endmodule

// File: tb/tb_pong_motion_ctrl.sv
`timescale 1ns/1ps
// Randomized bench for pong_motion_ctrl against a velocity-based
// reference model of the playfield.
module tb_pong_motion_ctrl;

    localparam int PH_IDLE = 0;
    localparam int PH_PLAY = 1;
    localparam int PH_MISS = 2;

    localparam int MAX_Y  = 480;
    localparam int BAR_MX = MAX_Y - 72;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] pixel_x = 10'd5;
    logic [9:0] pixel_y = 10'd5;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [9:0] bar_y_t, ball_x_l, ball_y_t;
    logic       ball_visible, frame_tick, hit, miss;

    always #5 clk = ~clk;

    pong_motion_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .bar_y_t      (bar_y_t),
        .ball_x_l     (ball_x_l),
        .ball_y_t     (ball_y_t),
        .ball_visible (ball_visible),
        .frame_tick   (frame_tick),
        .hit          (hit),
        .miss         (miss)
    );

    int n_vec = 0;
    int n_err = 0;
    int dut_hits = 0;
    int dut_misses = 0;

    int m_bar, m_x, m_y, m_vx, m_vy, m_vis, m_ph, m_mt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bar = 204;
        m_x   = 580;
        m_y   = 238;
        m_vx  = -2;
        m_vy  = 2;
        m_vis = 1;
        m_ph  = PH_IDLE;
        m_mt  = 0;
    endtask

    task automatic model_step(input logic u, input logic d,
                              output int eh, output int em);
        int ob;
        ob = m_bar;
        eh = 0;
        em = 0;
        if (u && !d) m_bar = (m_bar < 4) ? 0 : m_bar - 4;
        else if (d && !u) m_bar = (m_bar + 4 > BAR_MX) ? BAR_MX : m_bar + 4;
        case (m_ph)
            PH_IDLE: begin
                if (u || d) begin
                    m_ph = PH_PLAY;
                    m_vx = -2;
                    m_vy = 2;
                end
            end
            PH_PLAY: begin
                if (m_y <= 2) m_vy = 2;
                else if (m_y + 8 >= MAX_Y - 2) m_vy = -2;
                if (m_x > 603) begin
                    m_ph  = PH_MISS;
                    em    = 1;
                    m_vis = 0;
                    m_mt  = 0;
                end else begin
                    if (m_x <= 35 + 2) begin
                        m_vx = 2;
                    end else if (m_vx > 0 && m_x + 7 >= 598 && m_x + 7 <= 603
                                 && m_y + 7 >= ob && m_y <= ob + 71) begin
                        m_vx = -2;
                        eh   = 1;
                    end
                    m_x = m_x + m_vx;
                    m_y = m_y + m_vy;
                end
            end
            default: begin
                m_mt++;
                if (m_mt == 60) begin
                    m_ph  = PH_IDLE;
                    m_x   = 580;
                    m_y   = 238;
                    m_vis = 1;
                end
            end
        endcase
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_bar"}, int'(bar_y_t), m_bar);
        chk({tag, "_x"}, int'(ball_x_l), m_x);
        chk({tag, "_y"}, int'(ball_y_t), m_y);
        chk({tag, "_vis"}, int'(ball_visible), m_vis);
    endtask

    // caller is at a negedge; reset spans exactly one active edge
    task automatic do_reset_now();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk_state("rst");
        chk("rst_tick", int'(frame_tick), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_miss", int'(miss), 0);
    endtask

    task automatic tick(input logic u, input logic d);
        int eh, em;
        @(negedge clk);
        btn_up   = u;
        btn_down = d;
        pixel_x  = 10'd0;
        pixel_y  = 10'(MAX_Y + 1);
        chk("tick_low", int'(frame_tick), 0);
        @(negedge clk);
        pixel_x = 10'($urandom_range(1, 799));
        pixel_y = 10'($urandom_range(0, 524));
        chk("tick_high", int'(frame_tick), 1);
        chk_state("pre");
        @(negedge clk);
        model_step(u, d, eh, em);
        chk("tick_width", int'(frame_tick), 0);
        chk_state("upd");
        chk("hit", int'(hit), eh);
        chk("miss", int'(miss), em);
        if (hit) dut_hits++;
        if (miss) dut_misses++;
        btn_up   = ($urandom_range(0, 1) == 1);
        btn_down = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        chk("hit_width", int'(hit), 0);
        chk("miss_width", int'(miss), 0);
        chk_state("hold");
    endtask

    task automatic mid_reset();
        @(negedge clk);
        pixel_x  = 10'd0;
        pixel_y  = 10'(MAX_Y + 1);
        btn_up   = 1'b1;
        btn_down = 1'b1;
        @(negedge clk);
        chk("mid_tick", int'(frame_tick), 1);
        pixel_x = 10'd5;
        pixel_y = 10'd5;
        do_reset_now();
    endtask

    task automatic pick_track(output logic u, output logic d);
        int pc, bc;
        pc = m_bar + 36;
        bc = m_y + 4;
        u  = 1'b0;
        d  = 1'b0;
        if ($urandom_range(0, 5) == 0) begin
            u = ($urandom_range(0, 1) == 1);
            d = ($urandom_range(0, 1) == 1);
        end else if (pc < bc - 2) begin
            d = 1'b1;
        end else if (pc > bc + 2) begin
            u = 1'b1;
        end
        if (m_ph == PH_IDLE && !u && !d) d = 1'b1;
    endtask

    initial begin
        logic u, d;
        @(negedge clk);
        do_reset_now();

        repeat (3) tick(1'b0, 1'b0);
        chk("idle_x", int'(ball_x_l), 580);
        chk("idle_y", int'(ball_y_t), 238);
        chk("idle_bar", int'(bar_y_t), 204);

        tick(1'b0, 1'b1);
        chk("serve_bar", int'(bar_y_t), 208);
        chk("serve_x", int'(ball_x_l), 580);
        chk("serve_y", int'(ball_y_t), 238);

        repeat (117) tick(1'b0, 1'b0);
        chk("bottom_y", int'(ball_y_t), 468);
        chk("bottom_x", int'(ball_x_l), 346);

        @(negedge clk);
        do_reset_now();
        repeat (60) tick(1'b1, 1'b0);
        chk("bar_floor", int'(bar_y_t), 0);
        repeat (4) tick(1'b1, 1'b1);
        chk("bar_both", int'(bar_y_t), 0);

        for (int i = 0; i < 1200; i++) begin
            pick_track(u, d);
            tick(u, d);
        end
        chk("hit_seen", (dut_hits > 0) ? 1 : 0, 1);

        for (int i = 0; i < 50 && m_ph != PH_PLAY; i++) tick(1'b0, 1'b1);
        mid_reset();

        for (int i = 0; i < 5000 && dut_misses == 0; i++) tick(1'b1, 1'b0);
        chk("miss_seen", dut_misses, 1);
        repeat (20) tick(1'b0, 1'b0);
        chk("miss_hidden", int'(ball_visible), 0);
        mid_reset();

        for (int i = 0; i < 5000 && dut_misses < 2; i++) tick(1'b1, 1'b0);
        chk("miss_seen2", dut_misses, 2);
        repeat (59) tick(1'b0, 1'b0);
        chk("still_hidden", int'(ball_visible), 0);
        tick(1'b0, 1'b0);
        chk("reserve_vis", int'(ball_visible), 1);
        chk("reserve_x", int'(ball_x_l), 580);
        chk("reserve_y", int'(ball_y_t), 238);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
